// File: rtl/approx_add_pipe.sv
`timescale 1ns/1ps
// Pipelined approximate unsigned adder: selectable lower-part approximation, segmented
// upper-part carry pipeline, valid/ready stream and on-line error statistics.
module approx_add_pipe #(
    parameter int W  = 12,
    parameter int K  = 4,
    parameter int P  = 2,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic [1:0]    i_mode,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    output logic [W:0]    o_o,
    output logic [W:0]    o_err,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    input  logic          i_stat_clr,
    output logic [CW-1:0] o_err_cnt,
    output logic [W:0]    o_wce
);
    localparam int SEG = (W - K + P - 1) / P;

    logic [P-1:0]  r_vld;
    logic [1:0]    r_mode;
    logic [W-1:0]  r_a  [P];
    logic [W-1:0]  r_b  [P];
    logic [W-1:0]  r_sa [P];
    logic [W-1:0]  r_se [P];
    logic          r_ca [P];
    logic          r_ce [P];
    logic [CW-1:0] r_err_cnt;
    logic [W:0]    r_wce;

    logic [W-1:0]  w_sa [P];
    logic [W-1:0]  w_se [P];
    logic [P-1:0]  w_ca;
    logic [P-1:0]  w_ce;
    logic [P-1:0]  w_load;
    logic [K:0]    w_lo_ex;
    logic [K-1:0]  w_lo_apx;
    logic          w_lo_ca;
    logic [W:0]    w_apx;
    logic [W:0]    w_ex;
    logic [W:0]    w_err;
    logic          w_hs;

    // Ripple-adds bits lo..hi onto base; an empty range just forwards the carry.
    function automatic logic [W:0] seg_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] base, input logic cin,
                                           input int lo, input int hi);
        logic [W-1:0] s;
        logic         c;
        s = base;
        c = cin;
        for (int j = 0; j < W; j++) begin
            if (j >= lo && j <= hi) begin
                s[j] = a[j] ^ b[j] ^ c;
                c    = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
            end
        end
        return {c, s};
    endfunction

    always_comb begin
        w_lo_ex  = {1'b0, r_a[0][K-1:0]} + {1'b0, r_b[0][K-1:0]};
        w_lo_apx = w_lo_ex[K-1:0];
        w_lo_ca  = w_lo_ex[K];
        case (r_mode)
            2'd1: begin
                w_lo_apx = r_a[0][K-1:0] | r_b[0][K-1:0];
                w_lo_ca  = r_a[0][K-1] & r_b[0][K-1];
            end
            2'd2: begin
                w_lo_apx = r_b[0][K-1:0];
                w_lo_ca  = r_a[0][K-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [W:0] v_ap;
        logic [W:0] v_ex;
        int         v_lo;
        int         v_hi;
        for (int s = 0; s < P; s++) begin
            v_lo = K + s * SEG;
            v_hi = (s == P - 1) ? W - 1 : K + (s + 1) * SEG - 1;
            if (s == 0) begin
                v_ap = seg_add(r_a[0], r_b[0], {{(W-K){1'b0}}, w_lo_apx}, w_lo_ca, v_lo, v_hi);
                v_ex = seg_add(r_a[0], r_b[0], {{(W-K){1'b0}}, w_lo_ex[K-1:0]}, w_lo_ex[K],
                               v_lo, v_hi);
            end else begin
                v_ap = seg_add(r_a[s], r_b[s], r_sa[s], r_ca[s], v_lo, v_hi);
                v_ex = seg_add(r_a[s], r_b[s], r_se[s], r_ce[s], v_lo, v_hi);
            end
            w_sa[s] = v_ap[W-1:0];
            w_ca[s] = v_ap[W];
            w_se[s] = v_ex[W-1:0];
            w_ce[s] = v_ex[W];
        end
    end

    // A stage can load if the consumer is ready or any stage from here to the output is empty.
    always_comb begin
        logic v_ok;
        v_ok   = i_out_ready;
        w_load = '0;
        for (int s = P - 1; s >= 0; s--) begin
            v_ok      = v_ok | ~r_vld[s];
            w_load[s] = v_ok;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld  <= '0;
            r_mode <= 2'd0;
            for (int s = 0; s < P; s++) begin
                r_a[s]  <= '0;
                r_b[s]  <= '0;
                r_sa[s] <= '0;
                r_se[s] <= '0;
                r_ca[s] <= 1'b0;
                r_ce[s] <= 1'b0;
            end
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= i_in_valid;
                if (i_in_valid) begin
                    r_a[0]  <= i_a;
                    r_b[0]  <= i_b;
                    r_mode  <= (i_mode == 2'd3) ? 2'd0 : i_mode;
                end
            end
            for (int s = 1; s < P; s++) begin
                if (w_load[s]) begin
                    r_vld[s] <= r_vld[s-1];
                    if (r_vld[s-1]) begin
                        r_a[s]  <= r_a[s-1];
                        r_b[s]  <= r_b[s-1];
                        r_sa[s] <= w_sa[s-1];
                        r_se[s] <= w_se[s-1];
                        r_ca[s] <= w_ca[s-1];
                        r_ce[s] <= w_ce[s-1];
                    end
                end
            end
        end
    end

    assign w_apx       = {w_ca[P-1], w_sa[P-1]};
    assign w_ex        = {w_ce[P-1], w_se[P-1]};
    assign w_err       = (w_ex >= w_apx) ? (w_ex - w_apx) : (w_apx - w_ex);
    assign w_hs        = r_vld[P-1] & i_out_ready;
    assign o_o         = w_apx;
    assign o_err       = w_err;
    assign o_out_valid = r_vld[P-1];
    assign o_in_ready  = w_load[0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_stat_clr) begin
            r_err_cnt <= '0;
            r_wce     <= '0;
        end else if (w_hs) begin
            if (w_err != '0 && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_err > r_wce) r_wce <= w_err;
        end
    end

    assign o_err_cnt = r_err_cnt;
    assign o_wce     = r_wce;

endmodule

// File: tb/tb_approx_add_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for approx_add_pipe: directed vectors, a randomised backpressured
// stream, counter saturation/clear, and two extra parameter sets.
module tb_approx_add_pipe;
    localparam int NSW = 40;

    logic        clk;
    logic        rst_n;
    logic [11:0] a, bv;
    logic [1:0]  mode;
    logic        in_valid, out_ready, stat_clr;

    logic        m_in_ready, m_out_valid;
    logic [12:0] m_o, m_err, m_wce;
    logic [15:0] m_err_cnt;
    logic        c_in_ready, c_out_valid;
    logic [12:0] c_o, c_err, c_wce;
    logic [1:0]  c_err_cnt;

    logic [15:0] s_a, s_b;
    logic [1:0]  s_mode;
    logic        s_valid, s_ready, s_clr;
    logic        e_in_ready, e_out_valid;
    logic [8:0]  e_o, e_err, e_wce;
    logic [15:0] e_err_cnt;
    logic        f_in_ready, f_out_valid;
    logic [16:0] f_o, f_err, f_wce;
    logic [15:0] f_err_cnt;

    int n_chk, n_err;
    logic [31:0] q_o[$], q_e[$];
    logic [15:0] sw_a [NSW];
    logic [15:0] sw_b [NSW];
    logic [1:0]  sw_m [NSW];

    approx_add_pipe #(.W(12), .K(4), .P(2), .CW(16)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(bv), .i_mode(mode),
        .i_in_valid(in_valid), .o_in_ready(m_in_ready), .o_o(m_o), .o_err(m_err),
        .o_out_valid(m_out_valid), .i_out_ready(out_ready), .i_stat_clr(stat_clr),
        .o_err_cnt(m_err_cnt), .o_wce(m_wce));

    approx_add_pipe #(.W(12), .K(4), .P(2), .CW(2)) u_cw2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(bv), .i_mode(mode),
        .i_in_valid(in_valid), .o_in_ready(c_in_ready), .o_o(c_o), .o_err(c_err),
        .o_out_valid(c_out_valid), .i_out_ready(out_ready), .i_stat_clr(stat_clr),
        .o_err_cnt(c_err_cnt), .o_wce(c_wce));

    approx_add_pipe #(.W(8), .K(3), .P(1), .CW(16)) u_w8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(s_a[7:0]), .i_b(s_b[7:0]), .i_mode(s_mode),
        .i_in_valid(s_valid), .o_in_ready(e_in_ready), .o_o(e_o), .o_err(e_err),
        .o_out_valid(e_out_valid), .i_out_ready(s_ready), .i_stat_clr(s_clr),
        .o_err_cnt(e_err_cnt), .o_wce(e_wce));

    approx_add_pipe #(.W(16), .K(6), .P(5), .CW(16)) u_w16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(s_a), .i_b(s_b), .i_mode(s_mode),
        .i_in_valid(s_valid), .o_in_ready(f_in_ready), .o_o(f_o), .o_err(f_err),
        .o_out_valid(f_out_valid), .i_out_ready(s_ready), .i_stat_clr(s_clr),
        .o_err_cnt(f_err_cnt), .o_wce(f_wce));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_o(input int k, input logic [31:0] x,
                                            input logic [31:0] y, input logic [1:0] m);
        logic [31:0] mk, lo;
        logic        c;
        mk = (32'd1 << k) - 32'd1;
        if (m == 2'd1) begin
            lo = (x | y) & mk;
            c  = x[k-1] & y[k-1];
        end else if (m == 2'd2) begin
            lo = y & mk;
            c  = x[k-1];
        end else begin
            return x + y;
        end
        return (((x >> k) + (y >> k) + {31'd0, c}) << k) | lo;
    endfunction

    function automatic logic [31:0] model_e(input int k, input logic [31:0] x,
                                            input logic [31:0] y, input logic [1:0] m);
        logic [31:0] o, ex;
        o  = model_o(k, x, y, m);
        ex = x + y;
        return (ex >= o) ? ex - o : o - ex;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [11:0] ta, input logic [11:0] tb_v, input logic [1:0] tm,
                        input logic [12:0] eo, input logic [12:0] ee, input logic clr);
        a = ta; bv = tb_v; mode = tm; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_early", m_out_valid, 0);
        tick();
        check("beat_vld", m_out_valid, 1);
        check("beat_o", m_o, eo);
        check("beat_err", m_err, ee);
        check("cw2_o", c_o, eo);
        check("cw2_err", c_err, ee);
        stat_clr = clr;
        tick();
        stat_clr = 1'b0;
    endtask

    initial begin
        int sent, got, rnd_cnt;
        logic [31:0] rnd_wce, po, pe;
        logic stall_prev, acc;
        logic [31:0] e8_cnt, e8_wce, e16_cnt, e16_wce, tmp;

        n_chk = 0; n_err = 0;
        rst_n = 1'b0; a = '0; bv = '0; mode = '0; in_valid = 1'b0; out_ready = 1'b1;
        stat_clr = 1'b0; s_a = '0; s_b = '0; s_mode = '0; s_valid = 1'b0; s_ready = 1'b1;
        s_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // fill the pipe under backpressure, then reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1; a = 12'h555; bv = 12'h0AA; mode = 2'd1;
        repeat (3) tick();
        check("fill_vld", m_out_valid, 1);
        check("fill_rdy", m_in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check("rst_vld", m_out_valid, 0);
        check("rst_rdy", m_in_ready, 1);
        check("rst_o", m_o, 0);
        check("rst_err", m_err, 0);
        check("rst_cnt", m_err_cnt, 0);
        check("rst_wce", m_wce, 0);
        check("rst_cw2_vld", c_out_valid, 0);
        check("rst_cw2_rdy", c_in_ready, 1);

        beat(12'hFFF, 12'h001, 2'd0, 13'h1000, 13'd0, 1'b0);
        check("m0_cnt", m_err_cnt, 0);
        beat(12'h00F, 12'h001, 2'd2, 13'h011, 13'd1, 1'b0);
        beat(12'h00F, 12'h001, 2'd1, 13'h00F, 13'd1, 1'b0);
        check("two_cnt", m_err_cnt, 2);
        check("two_wce", m_wce, 1);
        beat(12'h123, 12'h456, 2'd3, 13'h579, 13'd0, 1'b0);
        beat(12'h888, 12'h888, 2'd1, 13'h1118, 13'd8, 1'b0);
        beat(12'hFFF, 12'h000, 2'd2, 13'h1000, 13'd1, 1'b0);
        beat(12'h007, 12'h008, 2'd2, 13'h008, 13'd7, 1'b0);
        check("five_cnt", m_err_cnt, 5);
        check("five_wce", m_wce, 8);
        check("sat_cnt", c_err_cnt, 3);
        beat(12'h007, 12'h008, 2'd2, 13'h008, 13'd7, 1'b1);
        check("clr_cnt", m_err_cnt, 0);
        check("clr_wce", m_wce, 0);
        check("clr_cw2_cnt", c_err_cnt, 0);
        check("clr_cw2_wce", c_wce, 0);

        // random stream with pseudo-random backpressure and input bubbles
        sent = 0; got = 0; rnd_cnt = 0; rnd_wce = 0; stall_prev = 1'b0; po = 0; pe = 0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            if (!in_valid && sent < 100 && $urandom_range(0, 4) != 0) begin
                a = 12'($urandom); bv = 12'($urandom); mode = 2'($urandom_range(0, 3));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stall_prev) begin
                check("stall_vld", m_out_valid, 1);
                check("stall_o", m_o, po);
                check("stall_err", m_err, pe);
            end
            if (m_out_valid && out_ready) begin
                check("rnd_q_nonempty", q_o.size() > 0, 1);
                if (q_o.size() > 0) begin
                    tmp = q_e.pop_front();
                    check("rnd_o", m_o, q_o.pop_front());
                    check("rnd_err", m_err, tmp);
                    if (tmp != 0) rnd_cnt++;
                    if (tmp > rnd_wce) rnd_wce = tmp;
                end
                got++;
            end
            stall_prev = m_out_valid && !out_ready;
            po = 32'(m_o); pe = 32'(m_err);
            acc = in_valid && m_in_ready;
            if (acc) begin
                q_o.push_back(model_o(4, 32'(a), 32'(bv), mode));
                q_e.push_back(model_e(4, 32'(a), 32'(bv), mode));
            end
            tick();
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
        end
        out_ready = 1'b1;
        check("rnd_delivered", got, 100);
        check("rnd_q_empty", q_o.size(), 0);
        check("rnd_cnt", m_err_cnt, rnd_cnt);
        check("rnd_wce", m_wce, rnd_wce);
        check("rnd_cw2_cnt", c_err_cnt, (rnd_cnt > 3) ? 3 : rnd_cnt);

        // parameter sweep: W=8/K=3/P=1 and W=16/K=6/P=5 fed the same back-to-back beats
        e8_cnt = 0; e8_wce = 0; e16_cnt = 0; e16_wce = 0;
        for (int t = 0; t < NSW; t++) begin
            if (t < 3) begin
                sw_a[t] = 16'hFFFF; sw_b[t] = 16'hFFFF; sw_m[t] = 2'(t);
            end else begin
                sw_a[t] = 16'($urandom); sw_b[t] = 16'($urandom);
                sw_m[t] = (t == 3) ? 2'd3 : 2'($urandom_range(0, 3));
            end
            tmp = model_e(3, 32'(sw_a[t][7:0]), 32'(sw_b[t][7:0]), sw_m[t]);
            if (tmp != 0) e8_cnt++;
            if (tmp > e8_wce) e8_wce = tmp;
            tmp = model_e(6, 32'(sw_a[t]), 32'(sw_b[t]), sw_m[t]);
            if (tmp != 0) e16_cnt++;
            if (tmp > e16_wce) e16_wce = tmp;
        end
        for (int t = 0; t <= NSW + 5; t++) begin
            int i8, i16;
            if (t < NSW) begin
                s_a = sw_a[t]; s_b = sw_b[t]; s_mode = sw_m[t]; s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            check("w8_rdy", e_in_ready, 1);
            check("w16_rdy", f_in_ready, 1);
            i8 = t - 1;
            i16 = t - 5;
            check("w8_vld", e_out_valid, (i8 >= 0 && i8 < NSW));
            check("w16_vld", f_out_valid, (i16 >= 0 && i16 < NSW));
            if (i8 >= 0 && i8 < NSW) begin
                check("w8_o", e_o, model_o(3, 32'(sw_a[i8][7:0]), 32'(sw_b[i8][7:0]), sw_m[i8]));
                check("w8_err", e_err, model_e(3, 32'(sw_a[i8][7:0]), 32'(sw_b[i8][7:0]), sw_m[i8]));
            end
            if (i16 >= 0 && i16 < NSW) begin
                check("w16_o", f_o, model_o(6, 32'(sw_a[i16]), 32'(sw_b[i16]), sw_m[i16]));
                check("w16_err", f_err, model_e(6, 32'(sw_a[i16]), 32'(sw_b[i16]), sw_m[i16]));
            end
            tick();
        end
        check("w8_cnt", e_err_cnt, e8_cnt);
        check("w8_wce", e_wce, e8_wce);
        check("w16_cnt", f_err_cnt, e16_cnt);
        check("w16_wce", f_wce, e16_wce);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/approx_add_pipe.md
# approx_add_pipe

Parametrised, pipelined approximate unsigned adder. It generalises the fixed 12-bit lower-part-approximated adder family to any width W, any approximate lower-part width K, and a run-time selectable approximation mode. The upper part is split into P registered carry segments for FPGA timing. A valid/ready stream interface connects it to datapath producers and consumers. An on-line error monitor compares every result against the exact sum for in-system error characterisation.

## Interface
- W, 12: operand width; result is W+1 bits
- K, 4: approximate lower-part width, 1 ≤ K < W
- P, 2: pipeline stages, 1 ≤ P ≤ W−K
- CW, 16: error-counter width
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- A  in  W  operand A
- B  in  W  operand B
- MODE  in  2  0 exact, 1 LOA, 2 copy-B/carry-A, 3 reserved (treated as 0)
- IN_VALID  in  1  input beat valid
- IN_READY  out  1  stage 0 can accept
- O  out  W+1  result
- ERR  out  W+1  |exact − O| for the presented beat
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts
- STAT_CLR  in  1  clear statistics
- ERR_CNT  out  CW  count of delivered beats with ERR ≠ 0, saturating
- WCE  out  W+1  maximum ERR delivered since last clear

## Operation
- **Lower part (bits K−1:0), computed in stage 0.**
  - MODE 0: exact sum of A[K−1:0]+B[K−1:0]; its carry feeds the upper part.
  - MODE 1 (LOA): O[K−1:0] = A|B bitwise; carry-in to upper part = A[K−1]&B[K−1].
  - MODE 2: O[K−1:0] = B[K−1:0]; carry-in to upper part = A[K−1].
- **Upper part (bits W−1:K).** Exact ripple addition split into P segments.
  - Segments 0..P−2 are ceil((W−K)/P) bits wide; the last segment takes the remainder.
  - Segment i is added in stage i using the registered carry from stage i−1.
  - Already-computed bits and not-yet-used operand bits travel with the beat.
- **Carry-out.** O[W] is the carry-out of the last segment.
- **Mode capture.** MODE is captured with the beat and carried through the pipeline. Mode changes between beats are legal and affect only later beats.
- **Exact reference.** The exact sum A+B is computed in the same segmented manner in parallel. ERR = exact − O when exact ≥ O, else O − exact. MODE 0 always gives ERR = 0.
- **Statistics update on output handshake only** (OUT_VALID & OUT_READY):
  - ERR_CNT increments when ERR ≠ 0 and saturates at 2^CW−1.
  - WCE = max(WCE, ERR).
  - STAT_CLR has priority: in a cycle with STAT_CLR=1, both statistics are set to 0 and the concurrent handshake is not counted.
- **Handshake.**
  - Each stage holds a valid bit. A stage loads when it is empty or its contents move on in the same cycle.
  - The last stage moves on when OUT_READY=1.
  - IN_READY = stage 0 empty, or stage 0 advancing in this cycle.
  - Bubbles collapse, so throughput is 1 beat/cycle while OUT_READY=1.
  - O, ERR and OUT_VALID stay stable while OUT_VALID=1 and OUT_READY=0.

## Timing
- Latency is P cycles: a beat accepted at edge n has OUT_VALID=1 after edge n+P−1, assuming no backpressure.
- IN_READY depends combinationally on OUT_READY; there is no other combinational input-to-output path.
- Reset (RST_N=0 at an edge):
  - all stage valids = 0, OUT_VALID = 0;
  - O = 0, ERR = 0, ERR_CNT = 0, WCE = 0;
  - IN_READY = 1 from the first cycle after reset.
- Reset mid-operation discards in-flight beats; no partial result is presented.
- Simultaneous accept and deliver with a full pipe: both occur; occupancy is unchanged.

## Test plan
- Reset with W=12, K=4, P=2, pipe filled → after one RST_N=0 edge: OUT_VALID=0, ERR_CNT=0, WCE=0, IN_READY=1.
- MODE 0, A=0xFFF, B=0x001 → O=0x1000, ERR=0 two cycles after acceptance; ERR_CNT unchanged.
- MODE 2, A=0x00F, B=0x001 → O=0x011, ERR=1. MODE 1, same operands → O=0x00F, ERR=1. After both beats: ERR_CNT=2, WCE=1.
- Back-to-back stream of 100 random beats, MODE randomised per beat, OUT_READY toggled pseudo-randomly:
  - every O and ERR matches the golden model in order;
  - no beat is dropped or duplicated;
  - outputs are stable while stalled.
- Counter behaviour:
  - CW=2 with 5 erroneous beats → ERR_CNT saturates at 3.
  - STAT_CLR asserted during a handshake with ERR=7 → ERR_CNT=0 and WCE=0 on the next cycle.
- Parameter sweep (W=8, K=3, P=1) and (W=16, K=6, P=5), exhaustive or random operands → latency equals P, and results match the golden model.
